id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised ID/EX pipeline register with valid/ready flow control, flush, an optional skid slot and a saturating stall counter. It sits between the decode and execute stages and carries the decoded bundle {aluop, alusel, reg1, reg2, wd, wreg}. Unlike a plain ID/EX latch, it lets execute back-pressure decode without dropping or duplicating instructions, and it lets the pipeline flush in-flight work.

## Interface
Parameters:
- ALUOP_W, 8, width of aluop field
- ALUSEL_W, 3, width of alusel field
- DATA_W, 32, width of reg1/reg2
- ADDR_W, 5, width of destination register address
- SKID, 1, 1 = registered id_ready with one skid slot; 0 = single slot, combinational id_ready
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  discard all held and incoming beats this cycle
- id_valid  in  1  decode presents a bundle
- id_ready  out  1  block accepts a bundle this cycle
- id_aluop / id_alusel / id_reg1 / id_reg2 / id_wd / id_wreg  in  ALUOP_W/ALUSEL_W/DATA_W/DATA_W/ADDR_W/1  decoded bundle
- ex_valid  out  1  execute bundle valid
- ex_ready  in  1  execute consumes bundle this cycle
- ex_aluop / ex_alusel / ex_reg1 / ex_reg2 / ex_wd / ex_wreg  out  widths as above  bundle to execute
- stall_cnt  out  CNT_W  cycles with ex_valid=1 and ex_ready=0, saturating

## Operation
- Accept = id_valid & id_ready; consume = ex_valid & ex_ready.
- NOP bundle: aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, reg1=reg2=ZeroWord, wd=NOPRegAddr, wreg=WriteDisable. ex_* equal the NOP bundle whenever ex_valid=0.
- States (SKID=1): EMPTY, FULL (main holds a beat), SKID (main and skid hold beats).
  - EMPTY: accept -> main<=id, FULL; else stay.
  - FULL: consume & accept -> main<=id, stay FULL; consume & !accept -> main<=NOP, EMPTY; !consume & accept -> skid<=id, SKID; otherwise hold.
  - SKID: consume -> main<=skid, FULL; else hold. id_ready=0, so no accept is possible.
  - id_ready is a register: 1 in EMPTY/FULL, 0 in SKID.
- SKID=0: only EMPTY and FULL exist. id_ready = !ex_valid | ex_ready (combinational). The skid register is not instantiated.
- flush has the highest priority. Next state is EMPTY, main and skid load NOP, and a beat accepted in the same cycle is dropped. id_ready=1 the cycle after. stall_cnt is not cleared.
- stall_cnt increments when ex_valid & !ex_ready, holds at all-ones, and is cleared only by rst.
- Order is preserved. A beat is never duplicated, and a beat is never dropped except by flush.

## Timing
- Reset (async assert, sync release): state EMPTY, ex_valid=0, ex_* = NOP bundle, id_ready=1 (SKID=1), stall_cnt=0.
- Latency: a beat accepted at edge N is on ex_* with ex_valid=1 from edge N onward, i.e. one cycle from id_* to ex_*.
- Throughput: one beat per cycle while ex_ready=1.
- SKID=1: after the first stalled accept, id_ready deasserts at the next edge. At most 2 beats are held.
- rst mid-stall: all held beats are lost and outputs go to NOP immediately (asynchronous).
- flush together with consume: the consumed beat counts as delivered, and the state becomes EMPTY.

## Structure
- Shared defines (existing defines file): RstEnable, EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, WriteDisable. Add the state encodings IdExEmpty / IdExFull / IdExSkid.
- Bundle packing into a single vector of width ALUOP_W+ALUSEL_W+2*DATA_W+ADDR_W+1 is local to the module.
- One sub-module: sat_counter (CNT_W, inc, clear on rst), reusable for other stage stall counters.

## Test plan
- Reset, then id_valid=1 with aluop=8'h25, reg1=32'h1, reg2=32'h2, wd=5'd3, wreg=1 and ex_ready=1 -> the next cycle ex_valid=1 with the same fields, id_ready stays 1.
- Stream 10 beats with ex_ready=1 -> 10 consumes on consecutive cycles, in order, no bubbles.
- SKID=1: hold ex_ready=0 while sending beats A, B, C -> A in main, B in skid, id_ready=0, C not accepted. Release ex_ready -> A, B, C delivered in order. stall_cnt equals the number of stalled cycles.
- Assert flush in the SKID state with id_valid=1 -> the next cycle ex_valid=0, ex_* = NOP bundle, id_ready=1, and the incoming beat is never delivered.
- SKID=0: ex_ready=0 with ex_valid=1 -> id_ready=0 in the same cycle. Raising ex_ready -> id_ready=1 combinationally, and a one-per-cycle handoff follows.
- CNT_W=4, ex_ready=0 for 20 cycles -> stall_cnt saturates at 4'hF. Assert rst asynchronously mid-cycle -> stall_cnt=0 and ex_valid=0 before the next edge.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg
//   Shared pipeline defines: reset polarity, the NOP bundle field values
//   and the ID/EX register state encodings.
package id_ex_pipe_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    IdExEmpty = 2'd0,
    IdExFull  = 2'd1,
    IdExSkid  = 2'd2
  } id_ex_state_e;

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// sat_counter
//   Saturating up-counter for stage stall statistics. Counts one per
//   cycle while inc is high, sticks at all-ones, cleared only by rst.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   inc   - increment request
//   count - current count (CNT_W bits)
module sat_counter
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//   ID/EX pipeline register with valid/ready handshake, flush, optional
//   skid slot and a saturating stall counter.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - drop every held and incoming beat this cycle
//   id_valid/id_ready - decode-side handshake
//   id_*              - decoded bundle {aluop, alusel, reg1, reg2, wd, wreg}
//   ex_valid/ex_ready - execute-side handshake
//   ex_*              - bundle to execute (NOP bundle while ex_valid=0)
//   stall_cnt         - saturating count of cycles ex_valid & !ex_ready
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned BW = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 1;

  localparam logic [BW-1:0] NOP_BUNDLE = {
    ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP), DATA_W'(ZeroWord),
    DATA_W'(ZeroWord), ADDR_W'(NOPRegAddr), WriteDisable
  };

  id_ex_state_e    state_q, state_d;
  logic [BW-1:0]   main_q, main_d;
  logic [BW-1:0]   skid_q;
  logic            ex_valid_q, ex_valid_d;
  logic [BW-1:0]   id_bundle;
  logic            accept;
  logic            consume;

  assign id_bundle = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
  assign accept    = id_valid & id_ready;
  assign consume   = ex_valid_q & ex_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    unique case (state_q)
      IdExEmpty: begin
        if (accept) begin
          main_d  = id_bundle;
          state_d = IdExFull;
        end
      end
      IdExFull: begin
        if (consume && accept) begin
          main_d = id_bundle;
        end else if (consume) begin
          main_d  = NOP_BUNDLE;
          state_d = IdExEmpty;
        end else if (accept && (SKID != 0)) begin
          state_d = IdExSkid;
        end
      end
      IdExSkid: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = IdExFull;
        end
      end
      default: begin
        main_d  = NOP_BUNDLE;
        state_d = IdExEmpty;
      end
    endcase
    // Flush overrides everything, including a beat accepted this cycle.
    if (flush) begin
      main_d  = NOP_BUNDLE;
      state_d = IdExEmpty;
    end
    ex_valid_d = (state_d != IdExEmpty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= IdExEmpty;
      main_q     <= NOP_BUNDLE;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [BW-1:0] skid_d;
      logic          id_ready_q, id_ready_d;

      always_comb begin
        skid_d = skid_q;
        if (flush) begin
          skid_d = NOP_BUNDLE;
        end else if ((state_q == IdExFull) && !consume && accept) begin
          skid_d = id_bundle;
        end else if ((state_q == IdExSkid) && consume) begin
          skid_d = NOP_BUNDLE;
        end
        // Registered ready: only a held skid beat blocks decode.
        id_ready_d = (state_d != IdExSkid);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
          skid_q     <= NOP_BUNDLE;
          id_ready_q <= 1'b1;
        end else begin
          skid_q     <= skid_d;
          id_ready_q <= id_ready_d;
        end
      end

      assign id_ready = id_ready_q;
    end else begin : g_no_skid
      assign skid_q   = NOP_BUNDLE;
      assign id_ready = !ex_valid_q | ex_ready;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (ex_valid_q & ~ex_ready),
    .count(stall_cnt)
  );

  assign ex_valid = ex_valid_q;
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = main_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: SKID=1, default widths
  logic        a_rst, a_flush, a_id_valid, a_id_ready, a_id_wreg;
  logic [7:0]  a_id_aluop, a_ex_aluop;
  logic [2:0]  a_id_alusel, a_ex_alusel;
  logic [31:0] a_id_reg1, a_id_reg2, a_ex_reg1, a_ex_reg2;
  logic [4:0]  a_id_wd, a_ex_wd;
  logic        a_ex_valid, a_ex_ready, a_ex_wreg;
  logic [15:0] a_stall;

  // Instance B: SKID=0, CNT_W=4
  logic        b_rst, b_flush, b_id_valid, b_id_ready, b_id_wreg;
  logic [7:0]  b_id_aluop, b_ex_aluop;
  logic [2:0]  b_id_alusel, b_ex_alusel;
  logic [31:0] b_id_reg1, b_id_reg2, b_ex_reg1, b_ex_reg2;
  logic [4:0]  b_id_wd, b_ex_wd;
  logic        b_ex_valid, b_ex_ready, b_ex_wreg;
  logic [3:0]  b_stall;

  id_ex_pipe #(.SKID(1)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .id_valid(a_id_valid), .id_ready(a_id_ready),
    .id_aluop(a_id_aluop), .id_alusel(a_id_alusel), .id_reg1(a_id_reg1),
    .id_reg2(a_id_reg2), .id_wd(a_id_wd), .id_wreg(a_id_wreg),
    .ex_valid(a_ex_valid), .ex_ready(a_ex_ready),
    .ex_aluop(a_ex_aluop), .ex_alusel(a_ex_alusel), .ex_reg1(a_ex_reg1),
    .ex_reg2(a_ex_reg2), .ex_wd(a_ex_wd), .ex_wreg(a_ex_wreg),
    .stall_cnt(a_stall)
  );

  id_ex_pipe #(.SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_aluop(b_id_aluop), .id_alusel(b_id_alusel), .id_reg1(b_id_reg1),
    .id_reg2(b_id_reg2), .id_wd(b_id_wd), .id_wreg(b_id_wreg),
    .ex_valid(b_ex_valid), .ex_ready(b_ex_ready),
    .ex_aluop(b_ex_aluop), .ex_alusel(b_ex_alusel), .ex_reg1(b_ex_reg1),
    .ex_reg2(b_ex_reg2), .ex_wd(b_ex_wd), .ex_wreg(b_ex_wreg),
    .stall_cnt(b_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_id_valid = 1'b0; a_ex_ready = 1'b0;
    a_id_aluop = '0; a_id_alusel = '0; a_id_reg1 = '0; a_id_reg2 = '0;
    a_id_wd = '0; a_id_wreg = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_id_valid = 1'b0; b_ex_ready = 1'b0;
    b_id_aluop = '0; b_id_alusel = '0; b_id_reg1 = '0; b_id_reg2 = '0;
    b_id_wd = '0; b_id_wreg = 1'b0;

    #2;
    chk("rst_ex_valid", a_ex_valid, 0);
    chk("rst_id_ready", a_id_ready, 1);
    chk("rst_stall", a_stall, 0);
    chk("rst_ex_aluop", a_ex_aluop, 0);
    chk("rst_ex_wd", a_ex_wd, 0);
    chk("rst_ex_wreg", a_ex_wreg, 0);

    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // ---- single beat, ex_ready=1
    a_id_valid = 1'b1; a_id_aluop = 8'h25; a_id_alusel = 3'd1;
    a_id_reg1 = 32'h1; a_id_reg2 = 32'h2; a_id_wd = 5'd3; a_id_wreg = 1'b1;
    a_ex_ready = 1'b1;
    step();
    chk("t1_ex_valid", a_ex_valid, 1);
    chk("t1_ex_aluop", a_ex_aluop, 8'h25);
    chk("t1_ex_alusel", a_ex_alusel, 3'd1);
    chk("t1_ex_reg1", a_ex_reg1, 32'h1);
    chk("t1_ex_reg2", a_ex_reg2, 32'h2);
    chk("t1_ex_wd", a_ex_wd, 5'd3);
    chk("t1_ex_wreg", a_ex_wreg, 1);
    chk("t1_id_ready", a_id_ready, 1);
    a_id_valid = 1'b0;
    step();
    chk("t1_drain_valid", a_ex_valid, 0);
    chk("t1_drain_aluop", a_ex_aluop, 0);

    // ---- stream 10 beats back to back
    for (int i = 0; i < 10; i++) begin
      a_id_valid = 1'b1; a_id_reg1 = 32'd100 + 32'(i); a_id_aluop = 8'(i);
      step();
      chk("stream_valid", a_ex_valid, 1);
      chk("stream_reg1", a_ex_reg1, 32'd100 + 32'(i));
      chk("stream_ready", a_id_ready, 1);
    end
    a_id_valid = 1'b0;
    step();
    chk("stream_end_valid", a_ex_valid, 0);
    chk("stream_stall", a_stall, 0);

    // ---- skid: A, B, C with ex_ready=0
    a_ex_ready = 1'b0;
    a_id_valid = 1'b1; a_id_reg1 = 32'hA;
    step();
    chk("skA_ready", a_id_ready, 1);
    chk("skA_reg1", a_ex_reg1, 32'hA);
    a_id_reg1 = 32'hB;
    step();
    chk("skB_ready", a_id_ready, 0);
    chk("skB_reg1", a_ex_reg1, 32'hA);
    chk("skB_stall", a_stall, 1);
    a_id_reg1 = 32'hC;
    step();
    chk("skC_ready", a_id_ready, 0);
    chk("skC_reg1", a_ex_reg1, 32'hA);
    step();
    chk("skC2_stall", a_stall, 3);
    a_ex_ready = 1'b1;
    step();
    chk("rel_B_reg1", a_ex_reg1, 32'hB);
    chk("rel_B_ready", a_id_ready, 1);
    step();
    chk("rel_C_valid", a_ex_valid, 1);
    chk("rel_C_reg1", a_ex_reg1, 32'hC);
    a_id_valid = 1'b0;
    step();
    chk("rel_end_valid", a_ex_valid, 0);
    chk("rel_stall", a_stall, 3);

    // ---- flush while in the skid state
    a_ex_ready = 1'b0;
    a_id_valid = 1'b1; a_id_reg1 = 32'hD;
    step();
    a_id_reg1 = 32'hE;
    step();
    chk("fl_pre_ready", a_id_ready, 0);
    a_id_reg1 = 32'hF; a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_id_valid = 1'b0;
    chk("fl_valid", a_ex_valid, 0);
    chk("fl_aluop", a_ex_aluop, 0);
    chk("fl_reg1", a_ex_reg1, 0);
    chk("fl_wreg", a_ex_wreg, 0);
    chk("fl_ready", a_id_ready, 1);
    chk("fl_stall", a_stall, 5);
    a_ex_ready = 1'b1;
    step();
    chk("fl_after_valid", a_ex_valid, 0);
    step();
    chk("fl_after2_valid", a_ex_valid, 0);

    // ---- SKID=0: combinational id_ready
    b_ex_ready = 1'b0;
    b_id_valid = 1'b1; b_id_reg1 = 32'h11;
    #1;
    chk("b_ready_empty", b_id_ready, 1);
    step();
    chk("b_valid", b_ex_valid, 1);
    chk("b_ready_stalled", b_id_ready, 0);
    b_ex_ready = 1'b1;
    #1;
    chk("b_ready_comb", b_id_ready, 1);
    b_id_reg1 = 32'h22;
    step();
    chk("b_hand1", b_ex_reg1, 32'h22);
    b_id_reg1 = 32'h33;
    step();
    chk("b_hand2", b_ex_reg1, 32'h33);
    chk("b_stall0", b_stall, 0);

    // ---- saturation then async reset mid-cycle
    b_id_valid = 1'b0; b_ex_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("b_sat", b_stall, 4'hF);
    chk("b_sat_valid", b_ex_valid, 1);
    chk("b_sat_reg1", b_ex_reg1, 32'h33);
    #2;
    b_rst = 1'b1;
    #1;
    chk("b_arst_stall", b_stall, 0);
    chk("b_arst_valid", b_ex_valid, 0);
    chk("b_arst_reg1", b_ex_reg1, 0);
    @(negedge clk);
    b_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
